// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase instruction-sequencing FSM for the RISC-CPU.
// Drives the memory read/write strobes, the PC/IR-operand address select and
// the IR/PC/accumulator load strobes from the current phase, opcode and zero flag.
// Optional feature macro: CPU_HALT_EN. When it is defined, HLT freezes the
// controller in phase 4 until reset. When it is undefined, HLT executes as an
// 8-cycle NOP.
module cpu_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       data_e,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       halt
);

   typedef enum logic [2:0] {
      StInstAddr  = 3'd0,
      StInstFetch = 3'd1,
      StInstLoad  = 3'd2,
      StIdle      = 3'd3,
      StOpAddr    = 3'd4,
      StOpFetch   = 3'd5,
      StAluOp     = 3'd6,
      StStore     = 3'd7
   } phase_e;

   localparam logic [2:0] OpSkz = 3'b001;
   localparam logic [2:0] OpAdd = 3'b010;
   localparam logic [2:0] OpAnd = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;
   localparam logic [2:0] OpLda = 3'b101;
   localparam logic [2:0] OpSto = 3'b110;
   localparam logic [2:0] OpJmp = 3'b111;

   phase_e phase_q, phase_d;
   logic   halted;
   logic   aluop;
   logic   is_sto;
   logic   is_jmp;
   logic   is_skz;

`ifdef CPU_HALT_EN
   localparam logic [2:0] OpHlt = 3'b000;

   logic halted_q, halted_d;

   // Halted flag: set by HLT leaving phase 4; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   // Phase register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= StInstAddr;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Next phase: count up with natural 3-bit wrap; HLT parks the counter at phase 4.
   always_comb begin
      phase_d = phase_q;
`ifdef CPU_HALT_EN
      halted_d = halted_q;
      if (halted_q) begin
         phase_d = phase_q;
      end else if (phase_q == StOpAddr && opcode == OpHlt) begin
         halted_d = 1'b1;
      end else begin
         phase_d = phase_e'(phase_q + 3'd1);
      end
`else
      phase_d = phase_e'(phase_q + 3'd1);
`endif
   end

   assign aluop  = (opcode == OpAdd) || (opcode == OpAnd) ||
                   (opcode == OpXor) || (opcode == OpLda);
   assign is_sto = (opcode == OpSto);
   assign is_jmp = (opcode == OpJmp);
   assign is_skz = (opcode == OpSkz);

   // Output decode of phase/opcode/zero/halted; no registered stage.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      halt   = 1'b0;
      unique case (phase_q)
         StInstAddr: begin
            sel = 1'b1;
         end
         StInstFetch: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         StInstLoad, StIdle: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         StOpAddr: begin
            inc_pc = !halted;
`ifdef CPU_HALT_EN
            halt = (opcode == OpHlt) || halted;
`endif
         end
         StOpFetch: begin
            rd = aluop;
         end
         StAluOp: begin
            rd     = aluop;
            inc_pc = is_skz && zero;
            ld_pc  = is_jmp;
            data_e = is_sto;
         end
         StStore: begin
            rd     = aluop;
            inc_pc = is_jmp;
            ld_pc  = is_jmp;
            ld_ac  = aluop;
            data_e = is_sto;
            wr     = is_sto;
         end
      endcase
   end

   assign phase = phase_q;

endmodule
